// File: rtl/pipe_skid_stage_if.sv
// pipe_skid_stage_if
//   Handshake bundle for one pipeline stage (decode -> execute).
//   Upstream side : flush, in_valid, in_ready, in_ctrl, in_data
//   Downstream side: out_valid, out_ready, out_ctrl, out_data
//   in_data/out_data carry NUM_CH channels, channel k at [k*DATA_W +: DATA_W].
//   Modports:
//     master - the environment around the stage (drives upstream, sinks downstream)
//     slave  - the stage itself
interface pipe_skid_stage_if #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 4,
  parameter int CTRL_W = 24
);
  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [CTRL_W-1:0]        in_ctrl;
  logic [DATA_W*NUM_CH-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [CTRL_W-1:0]        out_ctrl;
  logic [DATA_W*NUM_CH-1:0] out_data;

  modport master (
    output flush, in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );

  modport slave (
    input  flush, in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );
endinterface

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage
//   Valid/ready pipeline register with a two-entry (main + skid) buffer so
//   that in_ready can be a flop output with no combinational path from
//   out_ready. Control bundle is forced to all-zero (NOP) whenever nothing
//   valid is presented; flush squashes both entries synchronously.
//
//   Ports:
//     clk        rising-edge clock
//     rst        asynchronous reset, active-high
//     bus        pipe_skid_stage_if.slave (flush, in_*, out_*)
//     stall_cnt  [15:0] saturating count of out_valid & !out_ready cycles
//                (present only when PIPE_SKID_STALL_CNT_EN is defined)
//
//   Optional feature macro: PIPE_SKID_STALL_CNT_EN
//
//   Interface parameters must match DATA_W/NUM_CH/CTRL_W of this module.
module pipe_skid_stage #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 4,
  parameter int CTRL_W = 24
) (
  input  logic                clk,
  input  logic                rst,
  pipe_skid_stage_if.slave    bus
`ifdef PIPE_SKID_STALL_CNT_EN
  ,
  output logic [15:0]         stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // no entry held
    ST_FULL  = 2'd1,  // main entry only
    ST_SKID  = 2'd2   // main + skid entry, upstream stalled
  } state_t;

  typedef struct packed {
    logic [CTRL_W-1:0]              ctrl;
    logic [NUM_CH-1:0][DATA_W-1:0]  data;
  } entry_t;

  state_t  r_state;
  logic    r_main_vld;
  logic    r_skid_vld;
  entry_t  r_main;
  entry_t  r_skid;

  entry_t  w_in;
  logic    w_accept;
  logic    w_pop;

  assign w_in.ctrl = bus.in_ctrl;
  assign w_in.data = bus.in_data;

  // in_ready depends only on the skid flop, so back-pressure is registered.
  assign w_accept = bus.in_valid & ~r_skid_vld;
  assign w_pop    = r_main_vld & bus.out_ready;

  // Single FSM: state, valids and both entries. flush outranks everything;
  // a same-cycle pop is simply absorbed since the main entry is discarded
  // after the downstream has already taken it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
      r_main     <= '0;
      r_skid     <= '0;
    end else if (bus.flush) begin
      r_state    <= ST_EMPTY;
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
      r_main     <= '0;
      r_skid     <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_main     <= w_in;
            r_main_vld <= 1'b1;
            r_state    <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (w_accept && w_pop) begin
            r_main  <= w_in;
          end else if (w_accept) begin
            // downstream stalled: park the new entry behind the main one
            r_skid     <= w_in;
            r_skid_vld <= 1'b1;
            r_state    <= ST_SKID;
          end else if (w_pop) begin
            // data is left in place; out_ctrl masking supplies the NOP
            r_main_vld <= 1'b0;
            r_state    <= ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (w_pop) begin
            r_main     <= r_skid;
            r_skid     <= '0;
            r_skid_vld <= 1'b0;
            r_state    <= ST_FULL;
          end
        end
        default: begin
          r_state    <= ST_EMPTY;
          r_main_vld <= 1'b0;
          r_skid_vld <= 1'b0;
          r_main     <= '0;
          r_skid     <= '0;
        end
      endcase
    end
  end

  assign bus.in_ready  = ~r_skid_vld;
  assign bus.out_valid = r_main_vld;
  assign bus.out_ctrl  = r_main.ctrl & {CTRL_W{r_main_vld}};

  // Data is presented unmasked; only control needs to read as NOP.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign bus.out_data[k*DATA_W +: DATA_W] = r_main.data[k];
  end

`ifdef PIPE_SKID_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (bus.flush) begin
      r_stall_cnt <= '0;
    end else if (r_main_vld && !bus.out_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage
//   Directed bench for pipe_skid_stage: reset, streaming, back-pressure,
//   flush, bubbles and (when PIPE_SKID_STALL_CNT_EN is defined) the stall
//   counter. Inputs change and outputs are sampled 1 time unit after the
//   rising edge.
module tb_pipe_skid_stage;
  localparam int DATA_W = 32;
  localparam int NUM_CH = 4;
  localparam int CTRL_W = 24;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  pipe_skid_stage_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CTRL_W(CTRL_W)) bus();

`ifdef PIPE_SKID_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  pipe_skid_stage #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CTRL_W(CTRL_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef PIPE_SKID_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Channel k carries d0+k so channel ordering is visible.
  task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [31:0] d0);
    bus.in_valid = v;
    bus.in_ctrl  = c;
    bus.in_data  = {d0 + 32'd3, d0 + 32'd2, d0 + 32'd1, d0};
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [CTRL_W-1:0] c,
                         input logic [31:0] d0);
    chk({tag, ".vld"}, 64'(bus.out_valid), 64'(v));
    chk({tag, ".ctrl"}, 64'(bus.out_ctrl), 64'(c));
    if (v) begin
      chk({tag, ".ch0"}, 64'(bus.out_data[31:0]), 64'(d0));
      chk({tag, ".ch3"}, 64'(bus.out_data[127:96]), 64'(d0 + 32'd3));
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, '0, 32'd0);
    #2;
    chk("rst.vld",  64'(bus.out_valid), 64'd0);
    chk("rst.ctrl", 64'(bus.out_ctrl), 64'd0);
    chk("rst.rdy",  64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Reset mid-cycle with both entries held
    drive(1'b1, 24'hA1, 32'h0A10);
    tick();
    drive(1'b1, 24'hA2, 32'h0A20);
    tick();
    chk("pre_rst.rdy", 64'(bus.in_ready), 64'd0);
    chk("pre_rst.vld", 64'(bus.out_valid), 64'd1);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst.vld",  64'(bus.out_valid), 64'd0);
    chk("mid_rst.ctrl", 64'(bus.out_ctrl), 64'd0);
    chk("mid_rst.data", 64'(|bus.out_data), 64'd0);
    chk("mid_rst.rdy",  64'(bus.in_ready), 64'd1);
    drive(1'b0, '0, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    chk("post_rst.vld", 64'(bus.out_valid), 64'd0);
    chk("post_rst.rdy", 64'(bus.in_ready), 64'd1);

    // Streaming, 8 entries, out_ready high
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, CTRL_W'(k + 1), 32'h100 + 32'(k));
      tick();
      chk_out($sformatf("stream%0d", k), 1'b1, CTRL_W'(k + 1), 32'h100 + 32'(k));
      chk($sformatf("stream%0d.rdy", k), 64'(bus.in_ready), 64'd1);
    end
    drive(1'b0, 24'hFFFFFF, 32'hDEAD);
    tick();
    chk_out("stream_end", 1'b0, '0, 32'd0);

    // Back-pressure: A, B fill both entries, C waits upstream
    bus.out_ready = 1'b0;
    drive(1'b1, 24'h11, 32'hA00);
    tick();
    chk_out("bp.A", 1'b1, 24'h11, 32'hA00);
    chk("bp.A.rdy", 64'(bus.in_ready), 64'd1);
    drive(1'b1, 24'h22, 32'hB00);
    tick();
    chk_out("bp.B", 1'b1, 24'h11, 32'hA00);
    chk("bp.B.rdy", 64'(bus.in_ready), 64'd0);
    drive(1'b1, 24'h33, 32'hC00);
    tick();
    chk_out("bp.hold", 1'b1, 24'h11, 32'hA00);
    chk("bp.hold.rdy", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    tick();
    chk_out("bp.popA", 1'b1, 24'h22, 32'hB00);
    chk("bp.popA.rdy", 64'(bus.in_ready), 64'd1);
    tick();
    chk_out("bp.popB", 1'b1, 24'h33, 32'hC00);
    drive(1'b0, '0, 32'd0);
    tick();
    chk_out("bp.popC", 1'b0, '0, 32'd0);

    // Flush while SKID; D offered in the same cycle must vanish
    bus.out_ready = 1'b0;
    drive(1'b1, 24'h44, 32'h400);
    tick();
    drive(1'b1, 24'h55, 32'h500);
    tick();
    drive(1'b1, 24'h66, 32'h600);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk_out("flush_skid", 1'b0, '0, 32'd0);
    chk("flush_skid.rdy",  64'(bus.in_ready), 64'd1);
    chk("flush_skid.data", 64'(|bus.out_data), 64'd0);
    drive(1'b0, 24'h66, 32'h600);
    bus.out_ready = 1'b1;
    tick();
    chk_out("flush_skid.noD", 1'b0, '0, 32'd0);

    // Flush while FULL with a same-cycle accept: accept discarded
    bus.out_ready = 1'b0;
    drive(1'b1, 24'h5A, 32'h5A0);
    tick();
    drive(1'b1, 24'h5B, 32'h5B0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    drive(1'b0, '0, 32'd0);
    chk_out("flush_full", 1'b0, '0, 32'd0);
    bus.out_ready = 1'b1;
    tick();
    chk_out("flush_full.after", 1'b0, '0, 32'd0);

    // Bubbles: garbage on in_ctrl with in_valid low reads as NOP
    drive(1'b1, 24'h77, 32'h700);
    tick();
    chk_out("bub.E", 1'b1, 24'h77, 32'h700);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 24'hFFFFFF, 32'hFFFF0000);
      tick();
      chk_out($sformatf("bub%0d", k), 1'b0, '0, 32'd0);
    end
    drive(1'b1, 24'h88, 32'h800);
    tick();
    chk_out("bub.F", 1'b1, 24'h88, 32'h800);
    drive(1'b0, '0, 32'd0);
    tick();

`ifdef PIPE_SKID_STALL_CNT_EN
    chk("stall.zero", 64'(stall_cnt), 64'd0);
    bus.out_ready = 1'b0;
    drive(1'b1, 24'h99, 32'h900);
    tick();
    drive(1'b0, '0, 32'd0);
    for (int k = 0; k < 5; k++) tick();
    chk("stall.five", 64'(stall_cnt), 64'd5);
    chk_out("stall.held", 1'b1, 24'h99, 32'h900);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("stall.flush", 64'(stall_cnt), 64'd0);
    drive(1'b1, 24'h9A, 32'h9A0);
    tick();
    drive(1'b0, '0, 32'd0);
    for (int k = 0; k < 70000; k++) tick();
    chk("stall.sat", 64'(stall_cnt), 64'hFFFF);
    tick();
    chk("stall.sat2", 64'(stall_cnt), 64'hFFFF);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
